ring_step_tracker: RTL and testbench

- Downstream consumer of the bidirectional ring counter's count bus.
- Samples the ring pattern and classifies each change as hold, step up, step down, ambiguous step or jump (parallel load).
- Maintains a modulo-WIDTH position and a signed revolution count, and flags a dead (all-zero) ring.
- Feeds status and telemetry logic.

---
 rtl/ring_pkg.sv | 42 ++++
 rtl/ring_step_classify.sv | 31 +++
 rtl/ring_step_tracker.sv | 120 ++++++++++++
 tb/tb_ring_step_tracker.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// Shared types and rotation helpers for the ring step tracker.
package ring_pkg;

    typedef enum logic [2:0] {
        RC_HOLD,
        RC_UP,
        RC_DOWN,
        RC_AMBIG,
        RC_JUMP
    } ring_class_t;

    localparam int RING_MAX_W = 32;
    localparam int RING_IDX_W = $clog2(RING_MAX_W);

    // Rotations work on a zero-padded word; only the low w bits carry the ring.
    function automatic logic [RING_MAX_W-1:0] ring_rotl(
        input logic [RING_MAX_W-1:0] x,
        input int                    w
    );
        logic [RING_MAX_W-1:0] r;
        r = '0;
        r[0] = x[RING_IDX_W'(w - 1)];
        for (int i = 1; i < RING_MAX_W; i++) begin
            if (i < w) r[i] = x[i-1];
        end
        return r;
    endfunction

    function automatic logic [RING_MAX_W-1:0] ring_rotr(
        input logic [RING_MAX_W-1:0] x,
        input int                    w
    );
        logic [RING_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < RING_MAX_W - 1; i++) begin
            if (i < w - 1) r[i] = x[i+1];
        end
        r[RING_IDX_W'(w - 1)] = x[0];
        return r;
    endfunction

endpackage

// File: rtl/ring_step_classify.sv
// Combinational classification of a ring transition from prev to ring.
module ring_step_classify
    import ring_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] ring,
    output ring_class_t      cls
);

    logic [RING_MAX_W-1:0] prev_ext;
    logic [RING_MAX_W-1:0] ring_ext;
    logic                  is_up;
    logic                  is_dn;

    assign prev_ext = RING_MAX_W'(prev);
    assign ring_ext = RING_MAX_W'(ring);
    assign is_up    = (ring_ext == ring_rotl(prev_ext, WIDTH));
    assign is_dn    = (ring_ext == ring_rotr(prev_ext, WIDTH));

    // A pattern that is both a left and right rotation (e.g. 1010) gives no direction.
    always_comb begin
        cls = RC_JUMP;
        if (ring == prev)        cls = RC_HOLD;
        else if (is_up && is_dn) cls = RC_AMBIG;
        else if (is_up)          cls = RC_UP;
        else if (is_dn)          cls = RC_DOWN;
    end

endmodule

// File: rtl/ring_step_tracker.sv
// Tracks ring position/revolutions from sampled ring patterns; flags dead ring.
// Optional stall detector built when RING_STALL_DET_EN is defined.
module ring_step_tracker
    import ring_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int REV_W       = 8,
    parameter int STALL_LIMIT = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         ring,
    input  logic                     clr_err,
    output logic                     step,
    output logic                     dir_up,
    output logic                     jump,
    output logic [$clog2(WIDTH)-1:0] pos,
    output logic [REV_W-1:0]         revs,
    output logic                     err,
    output logic                     stall
);

    localparam int                POS_W    = $clog2(WIDTH);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(WIDTH - 1);

    logic [WIDTH-1:0] prev;
    logic             primed;
    ring_class_t      cls;

    ring_step_classify #(.WIDTH(WIDTH)) u_classify (
        .prev (prev),
        .ring (ring),
        .cls  (cls)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            step   <= 1'b0;
            dir_up <= 1'b0;
            jump   <= 1'b0;
            pos    <= '0;
            revs   <= '0;
            err    <= 1'b0;
            prev   <= '0;
            primed <= 1'b0;
        end else begin
            step <= 1'b0;
            jump <= 1'b0;
            if (clr_err) err <= 1'b0;
            if (in_valid) begin
                prev <= ring;
                // A dead ring sample overrides a same-cycle clear.
                if (ring == '0) err <= 1'b1;
                if (!primed) begin
                    primed <= 1'b1;
                    pos    <= '0;
                end else begin
                    case (cls)
                        RC_AMBIG: step <= 1'b1;
                        RC_UP: begin
                            step   <= 1'b1;
                            dir_up <= 1'b1;
                            if (pos == POS_LAST) begin
                                pos  <= '0;
                                revs <= revs + REV_W'(1);
                            end else begin
                                pos <= pos + POS_W'(1);
                            end
                        end
                        RC_DOWN: begin
                            step   <= 1'b1;
                            dir_up <= 1'b0;
                            if (pos == '0) begin
                                pos  <= POS_LAST;
                                revs <= revs - REV_W'(1);
                            end else begin
                                pos <= pos - POS_W'(1);
                            end
                        end
                        RC_JUMP: begin
                            jump <= 1'b1;
                            pos  <= '0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef RING_STALL_DET_EN
    localparam int               CNT_W   = $clog2(STALL_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_LIMIT);

    logic [CNT_W-1:0] hold_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_cnt <= '0;
            stall    <= 1'b0;
        end else if (in_valid && primed) begin
            if (cls == RC_HOLD) begin
                if (hold_cnt != CNT_MAX) begin
                    hold_cnt <= hold_cnt + CNT_W'(1);
                    stall    <= ((hold_cnt + CNT_W'(1)) == CNT_MAX);
                end
            end else begin
                hold_cnt <= '0;
                stall    <= 1'b0;
            end
        end
    end
`else
    // Detector absent: output held low whatever the limit.
    localparam logic STALL_OFF = (STALL_LIMIT > 0) ? 1'b0 : 1'b0;
    assign stall = STALL_OFF;
`endif

endmodule

// File: tb/tb_ring_step_tracker.sv
// Self-checking bench for ring_step_tracker: arithmetic reference model plus directed vectors.
module tb_ring_step_tracker;

    localparam int W  = 4;
    localparam int RW = 8;
`ifdef RING_STALL_DET_EN
    localparam int SL = 4;
`else
    localparam int SL = 8;
`endif

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic [W-1:0]  ring;
    logic          clr_err;
    logic          step;
    logic          dir_up;
    logic          jump;
    logic [1:0]    pos;
    logic [RW-1:0] revs;
    logic          err;
    logic          stall;

    int checks = 0;
    int fails  = 0;
    bit checking = 0;

    ring_step_tracker #(.WIDTH(W), .REV_W(RW), .STALL_LIMIT(SL)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .ring     (ring),
        .clr_err  (clr_err),
        .step     (step),
        .dir_up   (dir_up),
        .jump     (jump),
        .pos      (pos),
        .revs     (revs),
        .err      (err),
        .stall    (stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position and revolutions kept as plain integers.
    int  m_pos, m_revs, m_hold;
    bit  m_step, m_dir, m_jump, m_err, m_stall, m_primed;
    int  m_prev;

    function automatic int rotl_m(input int x);
        return ((x << 1) | (x >> (W - 1))) & ((1 << W) - 1);
    endfunction

    function automatic int rotr_m(input int x);
        return ((x >> 1) | ((x & 1) << (W - 1))) & ((1 << W) - 1);
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_pos = 0; m_revs = 0; m_hold = 0; m_step = 0; m_dir = 0;
            m_jump = 0; m_err = 0; m_stall = 0; m_primed = 0; m_prev = 0;
        end else begin
            int r;
            bit up, dn;
            r = int'(ring);
            m_step = 0;
            m_jump = 0;
            if (clr_err) m_err = 0;
            if (in_valid) begin
                if (r == 0) m_err = 1;
                if (!m_primed) begin
                    m_primed = 1;
                    m_pos = 0;
                end else if (r == m_prev) begin
                    if (m_hold < SL) m_hold++;
                end else begin
                    m_hold = 0;
                    up = (r == rotl_m(m_prev));
                    dn = (r == rotr_m(m_prev));
                    if (up && dn) m_step = 1;
                    else if (up) begin
                        m_step = 1; m_dir = 1;
                        m_pos = (m_pos + 1) % W;
                        if (m_pos == 0) m_revs++;
                    end else if (dn) begin
                        m_step = 1; m_dir = 0;
                        m_pos = (m_pos + W - 1) % W;
                        if (m_pos == W - 1) m_revs--;
                    end else begin
                        m_jump = 1;
                        m_pos = 0;
                    end
                end
                m_prev = r;
            end
`ifdef RING_STALL_DET_EN
            m_stall = (m_hold == SL);
`else
            m_stall = 0;
`endif
        end
    end

    always @(negedge clock) begin
        if (checking) begin
            chk("model_step",   32'(step),   32'(m_step));
            chk("model_dir_up", 32'(dir_up), 32'(m_dir));
            chk("model_jump",   32'(jump),   32'(m_jump));
            chk("model_pos",    32'(pos),    32'(m_pos));
            chk("model_revs",   32'(revs),   32'(m_revs & ((1 << RW) - 1)));
            chk("model_err",    32'(err),    32'(m_err));
            chk("model_stall",  32'(stall),  32'(m_stall));
        end
    end

    task automatic drive(input logic v, input logic [W-1:0] r, input logic c);
        in_valid = v;
        ring     = r;
        clr_err  = c;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        ring     = '0;
        clr_err  = 1'b0;
        reset    = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int steps;
        in_valid = 1'b0;
        ring     = '0;
        clr_err  = 1'b0;
        reset    = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_pos",  32'(pos),  0);
        chk("reset_revs", 32'(revs), 0);
        chk("reset_err",  32'(err),  0);
        reset    = 1'b1;
        checking = 1;

        // 1: prime then single up step
        drive(1, 4'b0001, 0);
        chk("t1_prime_step", 32'(step), 0);
        drive(1, 4'b0010, 0);
        chk("t1_step",   32'(step),   1);
        chk("t1_dir_up", 32'(dir_up), 1);
        chk("t1_pos",    32'(pos),    1);
        chk("t1_revs",   32'(revs),   0);
        drive(0, 4'b0100, 0);
        chk("t1_pulse_clear", 32'(step), 0);

        // 2: full revolution upward
        do_reset();
        drive(1, 4'b0001, 0);
        steps = 0;
        drive(1, 4'b0010, 0); steps += int'(step);
        drive(1, 4'b0100, 0); steps += int'(step);
        drive(1, 4'b1000, 0); steps += int'(step);
        drive(1, 4'b0001, 0); steps += int'(step);
        chk("t2_pos",   32'(pos),  0);
        chk("t2_revs",  32'(revs), 1);
        chk("t2_steps", 32'(steps), 4);

        // 3: down across zero
        do_reset();
        drive(1, 4'b0001, 0);
        drive(1, 4'b1000, 0);
        chk("t3_step",   32'(step),   1);
        chk("t3_dir_up", 32'(dir_up), 0);
        chk("t3_pos",    32'(pos),    3);
        chk("t3_revs",   32'(revs),   32'h0FF);

        // 4: jump, up, then asynchronous reset mid-stream
        do_reset();
        drive(1, 4'b0010, 0);
        drive(1, 4'b1001, 0);
        chk("t4_jump",      32'(jump), 1);
        chk("t4_jump_pos",  32'(pos),  0);
        chk("t4_jump_step", 32'(step), 0);
        drive(1, 4'b0011, 0);
        chk("t4_up_step", 32'(step), 1);
        chk("t4_up_pos",  32'(pos),  1);
        #2 reset = 1'b0;
        #1;
        chk("t4_async_step", 32'(step),   0);
        chk("t4_async_dir",  32'(dir_up), 0);
        chk("t4_async_pos",  32'(pos),    0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        drive(1, 4'b0100, 0);
        chk("t4_reprime_step", 32'(step), 0);
        chk("t4_reprime_jump", 32'(jump), 0);
        chk("t4_reprime_pos",  32'(pos),  0);
        drive(1, 4'b1000, 0);
        chk("t4_after_pos", 32'(pos), 1);

        // 5: sticky err, set wins over clear
        do_reset();
        drive(1, 4'b0000, 0);
        chk("t5_err_set", 32'(err), 1);
        drive(1, 4'b0000, 1);
        chk("t5_set_wins", 32'(err), 1);
        drive(1, 4'b0001, 1);
        chk("t5_cleared", 32'(err), 0);
        chk("t5_jump",    32'(jump), 1);
        drive(1, 4'b0000, 0);
        drive(0, 4'b0000, 1);
        chk("t5_idle_clear", 32'(err), 0);

        // 6: ambiguous step, then stall detection
        do_reset();
        drive(1, 4'b1010, 0);
        drive(1, 4'b0101, 0);
        chk("t6_ambig_step", 32'(step),   1);
        chk("t6_ambig_pos",  32'(pos),    0);
        chk("t6_ambig_dir",  32'(dir_up), 0);
        do_reset();
        drive(1, 4'b0001, 0);
        drive(1, 4'b0001, 0);
        drive(1, 4'b0001, 0);
        drive(1, 4'b0001, 0);
        chk("t6_stall_pre", 32'(stall), 0);
        drive(1, 4'b0001, 0);
`ifdef RING_STALL_DET_EN
        chk("t6_stall_set", 32'(stall), 1);
`else
        chk("t6_stall_tied", 32'(stall), 0);
`endif
        drive(0, 4'b0001, 0);
        drive(1, 4'b0001, 0);
        drive(1, 4'b0001, 0);
`ifdef RING_STALL_DET_EN
        chk("t6_stall_sat", 32'(stall), 1);
`else
        chk("t6_stall_sat_tied", 32'(stall), 0);
`endif
        drive(1, 4'b0010, 0);
        chk("t6_stall_clr", 32'(stall), 0);
        chk("t6_up_pos",    32'(pos),   1);

        drive(0, 4'b0000, 0);
        checking = 0;
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
